// File: rtl/stage_mult.sv
// stage_mult: fixed-latency pipelined integer multiplier (low word of a*b).
// Runs beside the memory stage. One op per cycle enters S1 and leaves from SN
// MUL_STAGES cycles after issue. There is no stall path: write-back always
// accepts the result, so the pipe only shifts, flushes or resets.
//
// Handshake: valid_i is a one-cycle issue strobe with no ready. An op issued in
// cycle N shows mult_valid_result_o=1 for exactly cycle N+MUL_STAGES.
// wb_conflict_o warns the main pipe one cycle earlier.
// MUL_STAGES legal range is 2..8.
module stage_mult #(
  parameter int WD_SIZE        = 32,
  parameter int INSTR_REG_SIZE = 5,
  parameter int MUL_STAGES     = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  input  logic [WD_SIZE-1:0]        op_a_i,
  input  logic [WD_SIZE-1:0]        op_b_i,
  input  logic [INSTR_REG_SIZE-1:0] rd_i,
  input  logic                      ctrl_reg_write_i,
  input  logic                      flush_i,
  input  logic [INSTR_REG_SIZE-1:0] rs1_i,
  input  logic [INSTR_REG_SIZE-1:0] rs2_i,
  output logic [WD_SIZE-1:0]        mult_result_o,
  output logic                      mult_valid_result_o,
  output logic [INSTR_REG_SIZE-1:0] rd_mult_o,
  output logic                      ctrl_reg_write_ml_o,
  output logic                      wb_conflict_o,
  output logic                      raw_hazard_o,
  output logic                      busy_o
);

  localparam int LAST = MUL_STAGES - 1;

  // Stage i holds {valid, data, rd, wr}; index 0 is S1, index LAST is SN.
  logic [MUL_STAGES-1:0]     stg_valid;
  logic [MUL_STAGES-1:0]     stg_wr;
  logic [WD_SIZE-1:0]        stg_data [MUL_STAGES];
  logic [INSTR_REG_SIZE-1:0] stg_rd   [MUL_STAGES];

  // The low WD_SIZE bits of the full 2*WD_SIZE product are the same for
  // signed and unsigned operands, so only the low half is kept.
  logic [WD_SIZE-1:0] product_lo;
  assign product_lo = op_a_i * op_b_i;

  // Shift register: reset wins over flush, flush wins over a same-cycle issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= '0;
      stg_wr    <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        stg_data[i] <= '0;
        stg_rd[i]   <= '0;
      end
    end else begin
      if (flush_i) begin
        stg_valid <= '0;
      end else begin
        stg_valid <= {stg_valid[MUL_STAGES-2:0], valid_i};
      end
      stg_wr      <= {stg_wr[MUL_STAGES-2:0], ctrl_reg_write_i};
      stg_data[0] <= product_lo;
      stg_rd[0]   <= rd_i;
      for (int i = 1; i < MUL_STAGES; i++) begin
        stg_data[i] <= stg_data[i-1];
        stg_rd[i]   <= stg_rd[i-1];
      end
    end
  end

  // Result port comes straight from the SN register; data and rd read as zero when idle.
  assign mult_valid_result_o = stg_valid[LAST];
  assign mult_result_o       = stg_valid[LAST] ? stg_data[LAST] : '0;
  assign rd_mult_o           = stg_valid[LAST] ? stg_rd[LAST]   : '0;
  assign ctrl_reg_write_ml_o = stg_valid[LAST] & stg_wr[LAST] & (|stg_rd[LAST]);

  // S(N-1) full means SN (and write-back) is claimed next cycle.
  assign wb_conflict_o = stg_valid[LAST-1];
  assign busy_o        = |stg_valid;

  // Any pending writer of rs1/rs2 (SN included: not in the register file yet); x0 never hazards.
  always_comb begin
    raw_hazard_o = 1'b0;
    for (int i = 0; i < MUL_STAGES; i++) begin
      if (stg_valid[i] && stg_wr[i] && (stg_rd[i] != '0) &&
          ((stg_rd[i] == rs1_i) || (stg_rd[i] == rs2_i))) begin
        raw_hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stage_mult.sv
// tb_stage_mult: directed test of stage_mult with hand-computed expectations.
module tb_stage_mult;

  localparam int WD = 32;
  localparam int RW = 5;
  localparam int NS = 5;

  logic          clk;
  logic          reset;
  logic          valid_i;
  logic [WD-1:0] op_a_i;
  logic [WD-1:0] op_b_i;
  logic [RW-1:0] rd_i;
  logic          ctrl_reg_write_i;
  logic          flush_i;
  logic [RW-1:0] rs1_i;
  logic [RW-1:0] rs2_i;
  logic [WD-1:0] mult_result_o;
  logic          mult_valid_result_o;
  logic [RW-1:0] rd_mult_o;
  logic          ctrl_reg_write_ml_o;
  logic          wb_conflict_o;
  logic          raw_hazard_o;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WD-1:0] exp_q[$];

  stage_mult #(.WD_SIZE(WD), .INSTR_REG_SIZE(RW), .MUL_STAGES(NS)) dut (
    .clk                 (clk),
    .reset               (reset),
    .valid_i             (valid_i),
    .op_a_i              (op_a_i),
    .op_b_i              (op_b_i),
    .rd_i                (rd_i),
    .ctrl_reg_write_i    (ctrl_reg_write_i),
    .flush_i             (flush_i),
    .rs1_i               (rs1_i),
    .rs2_i               (rs2_i),
    .mult_result_o       (mult_result_o),
    .mult_valid_result_o (mult_valid_result_o),
    .rd_mult_o           (rd_mult_o),
    .ctrl_reg_write_ml_o (ctrl_reg_write_ml_o),
    .wb_conflict_o       (wb_conflict_o),
    .raw_hazard_o        (raw_hazard_o),
    .busy_o              (busy_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WD-1:0] got, input logic [WD-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to the next cycle: 2 time units past the edge, inputs change here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [WD-1:0] a, input logic [WD-1:0] b,
                       input logic [RW-1:0] rd, input logic wr);
    valid_i          = v;
    op_a_i           = a;
    op_b_i           = b;
    rd_i             = rd;
    ctrl_reg_write_i = wr;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0);
  endtask

  // Issue one op, wait for its result cycle, check the write-back port.
  task automatic run_single(input string tag, input logic [WD-1:0] a, input logic [WD-1:0] b,
                            input logic [RW-1:0] rd, input logic wr,
                            input logic [WD-1:0] exp_res, input logic exp_wr);
    drive(1'b1, a, b, rd, wr);
    step();
    idle();
    for (int c = 1; c < NS; c++) step();
    settle();
    check({tag, "_valid"}, WD'(mult_valid_result_o), 32'd1);
    check({tag, "_result"}, mult_result_o, exp_res);
    check({tag, "_rd"}, WD'(rd_mult_o), WD'(rd));
    check({tag, "_wr_ml"}, WD'(ctrl_reg_write_ml_o), WD'(exp_wr));
    step();
    settle();
    check({tag, "_done"}, WD'(busy_o), 32'd0);
  endtask

  initial begin
    logic [WD-1:0] va [5];
    logic [WD-1:0] vb [5];
    logic [WD-1:0] vp [5];
    va = '{32'd5, 32'd100, 32'h0001_0000, 32'h0000_FFFF, 32'd12345};
    vb = '{32'd9, 32'd3,   32'h0001_0000, 32'h0000_FFFF, 32'd1000};
    vp = '{32'd45, 32'd300, 32'h0000_0000, 32'hFFFE_0001, 32'd12345000};

    flush_i = 1'b0;
    rs1_i   = '0;
    rs2_i   = '0;

    // 1: reset held 3 cycles while valid_i is high
    reset = 1'b1;
    drive(1'b1, 32'd3, 32'd4, 5'd2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      settle();
      check("rst_valid", WD'(mult_valid_result_o), 32'd0);
      check("rst_result", mult_result_o, 32'd0);
      check("rst_busy", WD'(busy_o), 32'd0);
      check("rst_wbc", WD'(wb_conflict_o), 32'd0);
      check("rst_wr_ml", WD'(ctrl_reg_write_ml_o), 32'd0);
    end
    reset = 1'b0;
    idle();
    settle();
    check("rst_busy_after", WD'(busy_o), 32'd0);
    step();
    settle();
    check("rst_busy_after2", WD'(busy_o), 32'd0);

    // 2: 7*6 -> rd 5, with the wb_conflict warning one cycle before the result
    drive(1'b1, 32'd7, 32'd6, 5'd5, 1'b1);
    step();
    idle();
    for (int c = 1; c <= NS; c++) begin
      settle();
      check("t2_wbc", WD'(wb_conflict_o), WD'(c == NS - 1));
      check("t2_valid", WD'(mult_valid_result_o), WD'(c == NS));
      check("t2_busy", WD'(busy_o), 32'd1);
      if (c == NS) begin
        check("t2_result", mult_result_o, 32'd42);
        check("t2_rd", WD'(rd_mult_o), 32'd5);
        check("t2_wr_ml", WD'(ctrl_reg_write_ml_o), 32'd1);
      end else begin
        step();
      end
    end
    step();
    settle();
    check("t2_valid_off", WD'(mult_valid_result_o), 32'd0);
    check("t2_result_off", mult_result_o, 32'd0);

    // 3: wrap-around products
    run_single("t3_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, 32'h0000_0001, 1'b1);
    run_single("t3_8000", 32'h8000_0000, 32'd2, 5'd8, 1'b1, 32'h0000_0000, 1'b1);

    // 4: 5 back-to-back issues rd=1..5, rs1=3 hazard window
    rs1_i = 5'd3;
    rs2_i = 5'd31;
    for (int t = 0; t <= 10; t++) begin
      if (t < 5) begin
        drive(1'b1, va[t], vb[t], RW'(t + 1), 1'b1);
        exp_q.push_back(vp[t]);
      end else begin
        idle();
      end
      settle();
      check("t4_hazard", WD'(raw_hazard_o), WD'(t >= 3 && t <= 7));
      if (t >= 5 && t <= 9) begin
        check("t4_valid", WD'(mult_valid_result_o), 32'd1);
        check("t4_rd", WD'(rd_mult_o), WD'(t - 4));
        if (exp_q.size() > 0) check("t4_result", mult_result_o, exp_q.pop_front());
      end else begin
        check("t4_valid_off", WD'(mult_valid_result_o), 32'd0);
      end
      step();
    end
    check("t4_queue_empty", WD'(exp_q.size()), 32'd0);

    // 5: rd=x0 is delivered but never written and never hazards
    rs1_i = 5'd0;
    rs2_i = 5'd4;
    drive(1'b1, 32'd11, 32'd13, 5'd0, 1'b1);
    step();
    idle();
    settle();
    check("t5_hazard_x0", WD'(raw_hazard_o), 32'd0);
    for (int c = 1; c < NS; c++) step();
    settle();
    check("t5_valid", WD'(mult_valid_result_o), 32'd1);
    check("t5_result", mult_result_o, 32'd143);
    check("t5_wr_ml", WD'(ctrl_reg_write_ml_o), 32'd0);
    check("t5_hazard_x0_last", WD'(raw_hazard_o), 32'd0);
    step();

    // 5b: rd=4 with wr=0 is not a hazard either
    drive(1'b1, 32'd2, 32'd2, 5'd4, 1'b0);
    step();
    idle();
    settle();
    check("t5_hazard_nowr", WD'(raw_hazard_o), 32'd0);
    for (int c = 1; c < NS; c++) step();
    settle();
    check("t5_nowr_wr_ml", WD'(ctrl_reg_write_ml_o), 32'd0);
    check("t5_nowr_result", mult_result_o, 32'd4);
    step();

    // 6: flush with three in flight plus a fourth issuing
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, 32'd3, 32'(i + 2), RW'(10 + i), 1'b1);
        step();
      end
      if (v == 0) begin
        drive(1'b1, 32'd9, 32'd9, 5'd13, 1'b1);
        flush_i = 1'b1;
      end else begin
        drive(1'b1, 32'd9, 32'd9, 5'd13, 1'b1);
        reset = 1'b1;
      end
      settle();
      check(v == 0 ? "t6_busy_pre_flush" : "t6_busy_pre_reset", WD'(busy_o), 32'd1);
      step();
      flush_i = 1'b0;
      reset   = 1'b0;
      idle();
      settle();
      check(v == 0 ? "t6_busy_flush" : "t6_busy_reset", WD'(busy_o), 32'd0);
      for (int c = 0; c < NS + 2; c++) begin
        settle();
        check(v == 0 ? "t6_valid_flush" : "t6_valid_reset", WD'(mult_valid_result_o), 32'd0);
        step();
      end
    end

    // 7: pipe still works after flush/reset
    run_single("t7_after", 32'd25, 32'd4, 5'd9, 1'b1, 32'd100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
